// File: rtl/screen_sequencer.sv
// Game lifecycle sequencer: tracks menu/ready/run/finished screens, latches the
// first finisher and enforces a minimum finished-screen hold before returning to menu.
//
// state    | meaning
// ---------+---------------------------------------------------------
// MENU     | menu screen shown; waits for the menu to be released
// READY    | race armed; waits for the first player movement
// RUN      | race in progress; waits for a finisher or an abort
// FINISHED | winner frozen; hold timer runs before menu is accepted
module screen_sequencer #(
    parameter int NUM_PLAYERS = 4,
    parameter int POS_W       = 7,
    parameter int MAX_POS     = 109,
    parameter int HOLD_CYCLES = 1024,
    localparam int ID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PLAYERS*POS_W-1:0] player_pos,
    input  logic                         is_in_menu,
    output logic [1:0]                   current_screen,
    output logic [ID_W-1:0]              winner_id,
    output logic                         winner_valid,
    output logic                         screen_changed
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [POS_W-1:0]  FIN_POS  = POS_W'(MAX_POS);

    typedef enum logic [1:0] {
        S_MENU     = 2'b00,
        S_RUN      = 2'b01,
        S_FINISHED = 2'b10,
        S_READY    = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              any_finished;
    logic              any_moved;
    logic [ID_W-1:0]   first_fin;
    logic              latch_winner;
    logic              clear_winner;

    // Scan from the top index down so the lowest finished index wins ties.
    always_comb begin
        any_finished = 1'b0;
        any_moved    = 1'b0;
        first_fin    = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (player_pos[i*POS_W +: POS_W] >= FIN_POS) begin
                any_finished = 1'b1;
                first_fin    = ID_W'(i);
            end
            if (player_pos[i*POS_W +: POS_W] != '0) begin
                any_moved = 1'b1;
            end
        end
    end

    assign hold_done = (hold_cnt == HOLD_MAX);

    always_comb begin
        state_d      = state_q;
        latch_winner = 1'b0;
        unique case (state_q)
            S_MENU: begin
                if (!is_in_menu) state_d = S_READY;
            end
            S_READY: begin
                if (is_in_menu) begin
                    state_d = S_MENU;
                end else if (any_finished) begin
                    state_d      = S_FINISHED;
                    latch_winner = 1'b1;
                end else if (any_moved) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (is_in_menu) begin
                    state_d = S_MENU;
                end else if (any_finished) begin
                    state_d      = S_FINISHED;
                    latch_winner = 1'b1;
                end
            end
            S_FINISHED: begin
                if (hold_done && is_in_menu) state_d = S_MENU;
            end
            default: state_d = S_MENU;
        endcase
        clear_winner = (state_d == S_MENU) && (state_q != S_MENU);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_MENU;
            screen_changed <= 1'b0;
            winner_id      <= '0;
            winner_valid   <= 1'b0;
            hold_cnt       <= '0;
        end else begin
            state_q        <= state_d;
            screen_changed <= (state_d != state_q);
            if (latch_winner) begin
                winner_id    <= first_fin;
                winner_valid <= 1'b1;
            end else if (clear_winner) begin
                winner_id    <= '0;
                winner_valid <= 1'b0;
            end
            // Counter only moves while holding; it saturates at the hold limit.
            if (latch_winner) begin
                hold_cnt <= '0;
            end else if (state_q == S_FINISHED && !hold_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign current_screen = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: directed scenarios plus randomized
// races, all compared against a lifecycle model kept in the bench.
module tb_screen_sequencer;

    localparam int NP   = 4;
    localparam int PW   = 7;
    localparam int MAXP = 109;
    localparam int HOLD = 8;
    localparam int IDW  = 2;

    localparam logic [1:0] SCR_MENU = 2'b00;
    localparam logic [1:0] SCR_RUN  = 2'b01;
    localparam logic [1:0] SCR_FIN  = 2'b10;
    localparam logic [1:0] SCR_RDY  = 2'b11;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NP*PW-1:0]     player_pos;
    logic                 is_in_menu;
    logic [1:0]           current_screen;
    logic [IDW-1:0]       winner_id;
    logic                 winner_valid;
    logic                 screen_changed;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [1:0]     m_screen;
    logic [IDW-1:0] m_win;
    logic           m_valid;
    logic           m_changed;
    int             m_fin_cycles;

    screen_sequencer #(
        .NUM_PLAYERS(NP),
        .POS_W(PW),
        .MAX_POS(MAXP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .player_pos(player_pos),
        .is_in_menu(is_in_menu),
        .current_screen(current_screen),
        .winner_id(winner_id),
        .winner_valid(winner_valid),
        .screen_changed(screen_changed)
    );

    always #5 clk = ~clk;

    task automatic set_pos(input int idx, input int val);
        player_pos[idx*PW +: PW] = PW'(val);
    endtask

    function automatic int get_pos(input int idx);
        return int'(player_pos[idx*PW +: PW]);
    endfunction

    task automatic m_reset();
        m_screen     = SCR_MENU;
        m_win        = '0;
        m_valid      = 1'b0;
        m_changed    = 1'b0;
        m_fin_cycles = 0;
    endtask

    // One clock of the lifecycle rules, using the inputs present at the edge.
    task automatic m_step();
        logic [1:0] nxt;
        int         winner;
        bit         moved;
        nxt    = m_screen;
        winner = -1;
        moved  = 0;
        for (int i = 0; i < NP; i++) begin
            if (get_pos(i) >= MAXP && winner < 0) winner = i;
            if (get_pos(i) != 0) moved = 1;
        end
        case (m_screen)
            SCR_MENU: if (!is_in_menu) nxt = SCR_RDY;
            SCR_RDY: begin
                if (is_in_menu) nxt = SCR_MENU;
                else if (winner >= 0) nxt = SCR_FIN;
                else if (moved) nxt = SCR_RUN;
            end
            SCR_RUN: begin
                if (is_in_menu) nxt = SCR_MENU;
                else if (winner >= 0) nxt = SCR_FIN;
            end
            default: begin
                if (m_fin_cycles >= HOLD && is_in_menu) nxt = SCR_MENU;
                else m_fin_cycles = m_fin_cycles + 1;
            end
        endcase
        if (nxt == SCR_FIN && m_screen != SCR_FIN) begin
            m_win        = IDW'(winner);
            m_valid      = 1'b1;
            m_fin_cycles = 0;
        end
        if (nxt == SCR_MENU && m_screen != SCR_MENU) begin
            m_win   = '0;
            m_valid = 1'b0;
        end
        m_changed = (nxt != m_screen);
        m_screen  = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic clear_pos();
        for (int i = 0; i < NP; i++) set_pos(i, 0);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        is_in_menu = 1'b1;
        player_pos = '0;
        m_reset();
        #12;
        checks++;
        if ({current_screen, winner_valid, winner_id, screen_changed} !== {SCR_MENU, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got scr=%b v=%b id=%0d chg=%b, want 00/0/0/0",
                     current_screen, winner_valid, winner_id, screen_changed);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_menu_to_ready();
        tick();
        checks++;
        if (current_screen !== SCR_MENU || screen_changed !== 1'b0) begin
            errors++;
            $display("FAIL menu_hold: got scr=%b chg=%b, want 00/0", current_screen, screen_changed);
        end
        is_in_menu = 1'b0;
        tick();
        checks++;
        if (current_screen !== SCR_RDY || screen_changed !== 1'b1) begin
            errors++;
            $display("FAIL to_ready: got scr=%b chg=%b, want 11/1", current_screen, screen_changed);
        end
        tick();
        checks++;
        if (current_screen !== SCR_RDY || screen_changed !== 1'b0) begin
            errors++;
            $display("FAIL ready_selfloop: got scr=%b chg=%b, want 11/0", current_screen, screen_changed);
        end
    endtask

    task automatic test_race_red_wins();
        set_pos(1, 5);
        tick();
        checks++;
        if (current_screen !== SCR_RUN || screen_changed !== 1'b1 || winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_run: got scr=%b chg=%b v=%b, want 01/1/0",
                     current_screen, screen_changed, winner_valid);
        end
        set_pos(1, 108);
        tick();
        checks++;
        if (current_screen !== SCR_RUN) begin
            errors++;
            $display("FAIL below_finish: got scr=%b, want 01", current_screen);
        end
        set_pos(1, 109);
        tick();
        checks++;
        if ({current_screen, winner_valid, winner_id, screen_changed} !== {SCR_FIN, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL red_wins: got scr=%b v=%b id=%0d chg=%b, want 10/1/1/1",
                     current_screen, winner_valid, winner_id, screen_changed);
        end
        tick();
        checks++;
        if (screen_changed !== 1'b0 || current_screen !== SCR_FIN) begin
            errors++;
            $display("FAIL fin_selfloop: got scr=%b chg=%b, want 10/0", current_screen, screen_changed);
        end
    endtask

    // Leaves FINISHED with is_in_menu held; exits exactly HOLD+1 edges after entry.
    task automatic back_to_ready();
        is_in_menu = 1'b1;
        for (int i = 0; i < HOLD + 2; i++) tick();
        clear_pos();
        tick();
        is_in_menu = 1'b0;
        tick();
    endtask

    task automatic test_tie_and_freeze();
        back_to_ready();
        checks++;
        if (current_screen !== SCR_RDY || winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL rearm: got scr=%b v=%b, want 11/0", current_screen, winner_valid);
        end
        set_pos(0, 3);
        tick();
        set_pos(2, 109);
        set_pos(3, 109);
        tick();
        checks++;
        if ({current_screen, winner_valid, winner_id} !== {SCR_FIN, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL tie_lowest: got scr=%b v=%b id=%0d, want 10/1/2",
                     current_screen, winner_valid, winner_id);
        end
        set_pos(0, 120);
        tick();
        tick();
        checks++;
        if (winner_id !== 2'd2 || current_screen !== SCR_FIN) begin
            errors++;
            $display("FAIL winner_frozen: got scr=%b id=%0d, want 10/2", current_screen, winner_id);
        end
    endtask

    task automatic test_hold();
        // Re-enter FINISHED so the hold window starts fresh at a known edge.
        back_to_ready();
        set_pos(3, 110);
        tick();
        checks++;
        if ({current_screen, winner_id} !== {SCR_FIN, 2'd3}) begin
            errors++;
            $display("FAIL yellow_wins: got scr=%b id=%0d, want 10/3", current_screen, winner_id);
        end
        is_in_menu = 1'b1;
        for (int k = 1; k <= HOLD; k++) begin
            tick();
            checks++;
            if (current_screen !== SCR_FIN || winner_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got scr=%b v=%b, want 10/1", k, current_screen, winner_valid);
            end
        end
        tick();
        checks++;
        if ({current_screen, winner_valid, winner_id, screen_changed} !== {SCR_MENU, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL hold_exit: got scr=%b v=%b id=%0d chg=%b, want 00/0/0/1",
                     current_screen, winner_valid, winner_id, screen_changed);
        end
    endtask

    task automatic test_abort();
        clear_pos();
        is_in_menu = 1'b0;
        tick();
        set_pos(0, 50);
        tick();
        checks++;
        if (current_screen !== SCR_RUN) begin
            errors++;
            $display("FAIL abort_setup: got scr=%b, want 01", current_screen);
        end
        is_in_menu = 1'b1;
        tick();
        checks++;
        if ({current_screen, winner_valid, screen_changed} !== {SCR_MENU, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort: got scr=%b v=%b chg=%b, want 00/0/1",
                     current_screen, winner_valid, screen_changed);
        end
        is_in_menu = 1'b0;
        tick();
        set_pos(0, 109);
        is_in_menu = 1'b1;
        tick();
        checks++;
        if ({current_screen, winner_valid} !== {SCR_MENU, 1'b0}) begin
            errors++;
            $display("FAIL menu_priority: got scr=%b v=%b, want 00/0", current_screen, winner_valid);
        end
    endtask

    task automatic test_async_reset();
        clear_pos();
        is_in_menu = 1'b0;
        tick();
        set_pos(2, 127);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({current_screen, winner_valid, winner_id, screen_changed} !== {SCR_MENU, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got scr=%b v=%b id=%0d chg=%b, want 00/0/0/0",
                     current_screen, winner_valid, winner_id, screen_changed);
        end
        #1;
        rst_n      = 1'b1;
        is_in_menu = 1'b1;
        tick();
        checks++;
        if (current_screen !== SCR_MENU || screen_changed !== 1'b0) begin
            errors++;
            $display("FAIL resume_menu: got scr=%b chg=%b, want 00/0", current_screen, screen_changed);
        end
    endtask

    task automatic test_random();
        int v;
        for (int c = 0; c < 400; c++) begin
            if (m_screen == SCR_MENU && $urandom_range(0, 1) == 0) clear_pos();
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = get_pos(i) + int'($urandom_range(1, 30));
                    set_pos(i, (v > 127) ? 127 : v);
                end
            end
            if (m_screen == SCR_FIN) is_in_menu = ($urandom_range(0, 2) != 0);
            else is_in_menu = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if ({current_screen, winner_valid, winner_id, screen_changed} !==
                {m_screen, m_valid, m_win, m_changed}) begin
                errors++;
                $display("FAIL random_c%0d: got scr=%b v=%b id=%0d chg=%b, want %b/%b/%0d/%b",
                         c, current_screen, winner_valid, winner_id, screen_changed,
                         m_screen, m_valid, m_win, m_changed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_menu_to_ready();
        test_race_red_wins();
        test_tie_and_freeze();
        test_hold();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Registered, parametrised successor to the combinational screen router.
- Tracks the game lifecycle in a state machine: menu, ready, race running, finished.
- Latches the first player to reach the finish line and holds the finished screen for a minimum number of cycles before a return to menu is accepted.
- Sits between the player position counters and the screen renderers; its `current_screen` drives the display mux.

Parameters:
- NUM_PLAYERS, 4, number of racing players/channels (2..8).
- POS_W, 7, width of each player position.
- MAX_POS, 109, finish position; a player at or beyond it has finished.
- HOLD_CYCLES, 1024, minimum cycles FINISHED is held before `is_in_menu` is honoured; 0 means no hold.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- player_pos  in  NUM_PLAYERS*POS_W  packed positions; player i at bits [i*POS_W +: POS_W]; player 0 = green, 1 = red, 2 = blue, 3 = yellow.
- is_in_menu  in  1  menu request/active from the menu controller.
- current_screen  out  2  00 MENU, 01 RUN, 10 FINISHED, 11 READY.
- winner_id  out  max(1,$clog2(NUM_PLAYERS))  index of the latched winner.
- winner_valid  out  1  high while `winner_id` is meaningful.
- screen_changed  out  1  one-cycle pulse in the cycle after `current_screen` takes a new value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state MENU, `current_screen` = 00.
  - `winner_id` = 0, `winner_valid` = 0, `screen_changed` = 0.
  - hold counter = 0.
- All outputs are registered. Inputs are sampled on edge N; the resulting screen is visible after edge N, so latency is 1 cycle.
- Combinational terms, computed per cycle:
  - any_finished = some pos ≥ MAX_POS. The comparison is unsigned at POS_W.
  - any_moved = some pos ≠ 0.
  - first_fin = lowest index among finished players.
- MENU (00):
  - `!is_in_menu` → READY.
  - Otherwise stay.
- READY (11), priority order:
  - `is_in_menu` → MENU.
  - Else any_finished → FINISHED, latching the winner.
  - Else any_moved → RUN.
  - Else stay.
- RUN (01), priority order:
  - `is_in_menu` → MENU. This aborts the race; no winner is latched.
  - Else any_finished → FINISHED, latching the winner.
  - Else stay. A later return of all positions to 0 does not leave RUN.
- Winner latch:
  - On entry to FINISHED: `winner_id` ← first_fin, `winner_valid` ← 1, hold counter ← 0.
  - Simultaneous finishers are resolved to the lowest index.
- FINISHED (10):
  - Positions are ignored; the winner is frozen.
  - The hold counter increments each cycle and saturates at HOLD_CYCLES. It is $clog2(HOLD_CYCLES+1) bits wide, minimum 1.
  - Hold is done when counter == HOLD_CYCLES.
  - Hold done and `is_in_menu` → MENU.
  - `is_in_menu` before hold done is ignored; the level must still be high after hold done to be taken.
  - With HOLD_CYCLES = 0, exit is possible on the first cycle after entry.
- Any transition into MENU: clear `winner_valid` and `winner_id` in the same edge.
- `screen_changed` = 1 for exactly the cycle following any edge where state changed; otherwise 0. Self-loops never pulse.
- Reset mid-race or mid-hold: immediate return to reset values; the winner is lost.
- Invalid state encodings are not reachable. A default branch returns to MENU.

Test Plan:
1. Reset, `is_in_menu` = 1, all pos = 0, then drop `is_in_menu` → screen 00, then 11 one cycle after the drop; `screen_changed` pulses once.
2. From READY, set pos[red] = 5 → screen 01. Advance red to 109 → screen 10, `winner_id` = 1, `winner_valid` = 1, one `screen_changed` pulse per transition.
3. From RUN, blue and yellow reach 109 on the same edge → `winner_id` = 2. Later green = 120 → `winner_id` unchanged at 2.
4. With HOLD_CYCLES = 8: in FINISHED, assert `is_in_menu` on cycle 1 → stays 10 through hold. Hold `is_in_menu` high → screen 00 on the edge after the counter reaches 8, and `winner_valid` = 0.
5. In RUN with green = 50, assert `is_in_menu` → screen 00 next cycle, `winner_valid` stays 0. With READY and green = 109 and `is_in_menu` = 1 on the same edge → MENU wins.
6. Assert `rst_n` low asynchronously mid-FINISHED (between clock edges) → outputs go to 00/0/0 without a clock edge; release → resume in MENU.
